axi_ram_responder: RTL and testbench
====================================

# axi_ram_responder

AXI3 slave memory model that answers the master-side AXI port of the CPU top in the non-fixed-latency build. It holds a word-addressed RAM and serves single-ID read and write bursts with FIXED, INCR and WRAP addressing. A configurable read latency lets it stand in for slow memory. It lives in the simulation/test harness and responds to the requests produced behind the core's bus converter.

## Interface
Parameters:
- `ADDR_BITS`, default 10: word-index width; RAM depth is 2^ADDR_BITS words (4 KiB at default).
- `READ_LATENCY`, default 0: extra idle cycles between the AR handshake and the first R beat.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`  in  4/32/4/3/2: read address channel.
- `arlock`/`arcache`/`arprot`  in  2/4/3: ignored.
- `arvalid` in 1, `arready` out 1: AR handshake.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid`  out  4/32/2/1/1, `rready` in 1: read data channel.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`  in  4/32/4/3/2, `awlock`/`awcache`/`awprot` ignored, `awvalid` in, `awready` out: write address channel.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid`  in  4/32/4/1/1, `wready` out 1: write data channel. `wid` is ignored.
- `bid`/`bresp`/`bvalid`  out  4/2/1, `bready` in 1: write response channel.

## Operation
- Read and write engines are independent. Each engine has at most one burst outstanding.
- RAM word index is `addr[ADDR_BITS+1:2]`. Upper bits wrap modulo depth. `arsize`/`awsize` are ignored, and the beat stride is always 4 bytes.
- Burst addressing:
  - FIXED (00): the same word on every beat.
  - INCR (01): +4 per beat.
  - WRAP (10): +4 per beat, wrapping inside the block aligned to (len+1)*4 bytes. Valid only for 2/4/8/16 beats; any other length is treated as INCR.
  - Reserved (11): treated as INCR.
- Read FSM:
  - R_IDLE: `arready`=1. On AR handshake, capture id, addr, len and burst, then go to R_WAIT if READ_LATENCY>0, otherwise R_DATA.
  - R_WAIT: count READ_LATENCY cycles, then go to R_DATA.
  - R_DATA: `rvalid`=1 and `rdata` = RAM[current index]. On each R handshake, advance the address and decrement the beat count. `rlast`=1 on the final beat. Final handshake → R_IDLE.
- Write FSM:
  - W_IDLE: `awready`=1. On AW handshake, capture id, addr, len and burst → W_DATA.
  - W_DATA: `wready`=1. On each W handshake, write the bytes whose `wstrb` bit is set, then advance the address. The beat count alone ends the burst (→ W_RESP).
  - W_RESP: `bvalid`=1 and `bid` = captured id. On B handshake → W_IDLE.
- `rresp`/`bresp` = OKAY (00). Exception: `bresp` = SLVERR (10) when `wlast` disagrees with the beat count on any beat of the burst. Writes are still performed in that case.
- `rid` = captured `arid`.
- Reset forces both FSMs to idle and zeroes the counters. RAM contents are never cleared by reset. A burst in flight when reset asserts is abandoned; no further beats and no B response are issued.

## Timing
- Reset values: `arready`=`awready`=`wready`=0, `rvalid`=`rlast`=`bvalid`=0, `rid`/`bid`/`rresp`/`bresp`=0, `rdata`=0.
- While `reset`=1 all outputs hold these values. `arready`/`awready` rise in the first cycle after reset deasserts.
- AR handshake in cycle T → first `rvalid` in cycle T+1+READ_LATENCY. With `rready` held high, beats then stream one per cycle.
- `rvalid`/`rdata`/`rlast`/`rid` stay stable while `rready`=0.
- AW handshake in cycle T → `wready` from cycle T+1. Final W handshake in cycle U → `bvalid` in cycle U+1.
- A write beat accepted in cycle N is visible on `rdata` from cycle N+1. A same-cycle read of the same word returns the old data.
- `arready` and `awready` are never high while the corresponding engine is busy. The AW and W channels are never accepted in the same cycle.

## Structure
- Package `axi_pkg`:
  - burst codes (FIXED/INCR/WRAP)
  - resp codes (OKAY/SLVERR)
  - read FSM state enum and write FSM state enum
  - `axi_len_t`/`axi_id_t` typedefs
- Sub-module `axi_burst_addr`: combinational next-address calculation from (addr, len, burst). Instantiated once per engine.

## Test plan
- Single read at reset contents: write 0xDEADBEEF to 0x40 with wstrb=F, then read arlen=0 at 0x40 → rdata=0xDEADBEEF, rlast=1, rresp=0, rid = arid.
- INCR write of 4 beats at 0x100 (data 1,2,3,4) then INCR read of 4 beats → rdata 1,2,3,4 with rlast only on beat 4. Random `rready` stalls must not change the data order.
- WRAP read of 4 beats at 0x108 after filling 0x100..0x10C with A,B,C,D → C,D,A,B.
- Partial strobe: word 0x11223344, then write 0xAABBCCDD with wstrb=0101 → read returns 0x11BB33DD. A write with `wlast` early on beat 2 of 4 → bresp=10.
- READ_LATENCY=3: AR handshake in cycle 10 → `rvalid` first high in cycle 14. Assert `reset` mid-burst → `rvalid` low next cycle, `arready` high after release, and RAM data retained.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI3 types and codes for the RAM responder.
// Burst/resp encodings, FSM states and channel field typedefs.
package axi_pkg;

    typedef logic [3:0] axi_len_t;
    typedef logic [3:0] axi_id_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED/INCR/WRAP bursts with a 4-byte stride.
// Unsupported WRAP lengths and the reserved code fall back to INCR.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] incr;
    logic [31:0] mask;
    logic        wrap_ok;

    always_comb begin
        incr      = addr + 32'd4;
        // WRAP window is (len+1)*4 bytes, so the in-window bits are {len,2'b11}
        mask      = {26'd0, len, 2'b11};
        wrap_ok   = (len == 4'd1) || (len == 4'd3) ||
                    (len == 4'd7) || (len == 4'd15);
        next_addr = incr;
        unique case (1'b1)
            burst == BURST_FIXED:
                next_addr = addr;
            (burst == BURST_WRAP) && wrap_ok:
                next_addr = (addr & ~mask) | (incr & mask);
            default:
                next_addr = incr;
        endcase
    end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI3 slave RAM model with independent single-burst read/write engines.
// Read path has a configurable start latency; RAM survives reset.
module axi_ram_responder
    import axi_pkg::*;
#(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [7:0] LAT_LOAD =
        (READ_LATENCY > 0) ? 8'(READ_LATENCY - 1) : 8'd0;

    logic [31:0] mem [DEPTH];

    logic unused_ok;
    assign unused_ok = ^{arsize, arlock, arcache, arprot,
                         awsize, awlock, awcache, awprot, wid};

    r_state_e       r_state, r_next;
    axi_id_t        r_id;
    axi_len_t       r_len, r_cnt;
    logic [1:0]     r_burst;
    logic [31:0]    r_addr, r_addr_nxt;
    logic [7:0]     r_lat;
    logic [ADDR_BITS-1:0] r_idx;
    logic           ar_hs, r_hs;

    w_state_e       w_state, w_next;
    axi_id_t        w_id;
    axi_len_t       w_len, w_cnt;
    logic [1:0]     w_burst;
    logic [31:0]    w_addr, w_addr_nxt;
    logic           w_err;
    logic [ADDR_BITS-1:0] w_idx;
    logic           aw_hs, w_hs, b_hs;

    assign r_idx = r_addr[ADDR_BITS+1:2];
    assign w_idx = w_addr[ADDR_BITS+1:2];

    // Handshakes come from state, not outputs, to keep comb paths one-way
    assign ar_hs = !reset && arvalid && (r_state == R_IDLE);
    assign r_hs  = !reset && rready  && (r_state == R_DATA);
    assign aw_hs = !reset && awvalid && (w_state == W_IDLE);
    assign w_hs  = !reset && wvalid  && (w_state == W_DATA);
    assign b_hs  = !reset && bready  && (w_state == W_RESP);

    axi_burst_addr u_raddr (
        .addr      (r_addr),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_addr_nxt)
    );

    axi_burst_addr u_waddr (
        .addr      (w_addr),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_addr_nxt)
    );

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = RESP_OKAY;
        unique case (r_state)
            R_IDLE: if (ar_hs)
                r_next = (READ_LATENCY > 0) ? R_WAIT : R_DATA;
            R_WAIT: if (r_lat == 8'd0)
                r_next = R_DATA;
            R_DATA: if (r_hs && (r_cnt == 4'd0))
                r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        if (!reset) begin
            arready = (r_state == R_IDLE);
            if (r_state == R_DATA) begin
                rvalid = 1'b1;
                rlast  = (r_cnt == 4'd0);
                rid    = r_id;
                rdata  = mem[r_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= BURST_INCR;
            r_lat   <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_id    <= arid;
                r_addr  <= araddr;
                r_len   <= arlen;
                r_cnt   <= arlen;
                r_burst <= arburst;
                r_lat   <= LAT_LOAD;
            end
            if ((r_state == R_WAIT) && (r_lat != 8'd0))
                r_lat <= r_lat - 8'd1;
            if (r_hs) begin
                r_addr <= r_addr_nxt;
                r_cnt  <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bid     = '0;
        bresp   = RESP_OKAY;
        unique case (w_state)
            W_IDLE: if (aw_hs) w_next = W_DATA;
            W_DATA: if (w_hs && (w_cnt == 4'd0)) w_next = W_RESP;
            W_RESP: if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
        if (!reset) begin
            awready = (w_state == W_IDLE);
            wready  = (w_state == W_DATA);
            if (w_state == W_RESP) begin
                bvalid = 1'b1;
                bid    = w_id;
                bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= BURST_INCR;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_cnt   <= awlen;
                w_burst <= awburst;
                w_err   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= w_addr_nxt;
                w_cnt  <= w_cnt - 4'd1;
                if (wlast != (w_cnt == 4'd0))
                    w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomized bench for axi_ram_responder against a burst-level memory model.
// A negedge monitor checks every channel each cycle; directed tests pin literals.
module tb_axi_ram_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axi_ram_responder #(.ADDR_BITS(10), .READ_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(2'b00), .arcache(4'h0), .arprot(3'h0),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(2'b00), .awcache(4'h0), .awprot(3'h0),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL timeout %s: got no handshake want handshake", name);
    endtask

    // Behavioural memory: data plus per-byte "written" flags
    logic [31:0] mm [1024];
    logic [3:0]  mk [1024];
    initial for (int i = 0; i < 1024; i++) mk[i] = 4'h0;

    function automatic int unsigned beat_addr(input int unsigned a,
            input int unsigned len, input int unsigned bt, input int unsigned i);
        int unsigned sz;
        if (bt == 0) return a;
        if (bt == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            sz = (len + 1) * 4;
            return (a / sz) * sz + ((a % sz) + 4 * i) % sz;
        end
        return a + 4 * i;
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    int unsigned rq[$];
    int unsigned wq[$];
    bit          r_busy = 0, w_busy = 0, b_pend = 0, w_err_m = 0;
    bit          first_wait = 0;
    int          r_start = 0, w_start = 0, b_start = 0;
    int          ar_cyc = 0, first_rv_cyc = 0;
    logic [3:0]  r_id_m = '0, w_id_m = '0;
    logic [1:0]  last_bresp = '0;
    logic [31:0] got_d[$];
    logic        got_l[$];
    logic [3:0]  got_id[$];

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_arready", 32'(arready), 32'd0);
            chk("rst_awready", 32'(awready), 32'd0);
            chk("rst_wready", 32'(wready), 32'd0);
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            chk("rst_bvalid", 32'(bvalid), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            rq.delete();
            wq.delete();
            r_busy = 0; w_busy = 0; b_pend = 0; first_wait = 0;
        end else begin
            logic        exp_rv, exp_bv, is_last;
            logic [31:0] m;
            int unsigned idx;
            chk("arready", 32'(arready), 32'(!r_busy));
            chk("awready", 32'(awready), 32'(!w_busy));
            chk("wready", 32'(wready),
                32'(w_busy && wq.size() > 0 && cyc >= w_start));
            exp_rv = rq.size() > 0 && cyc >= r_start;
            chk("rvalid", 32'(rvalid), 32'(exp_rv));
            if (rvalid && first_wait) begin
                first_rv_cyc = cyc;
                first_wait = 0;
            end
            if (rvalid && exp_rv) begin
                idx = rq[0];
                m = bmask(mk[idx]);
                chk("rlast", 32'(rlast), 32'(rq.size() == 1));
                chk("rid", 32'(rid), 32'(r_id_m));
                chk("rresp", 32'(rresp), 32'd0);
                if (m != 0) chk("rdata", rdata & m, mm[idx] & m);
                if (rready) begin
                    got_d.push_back(rdata);
                    got_l.push_back(rlast);
                    got_id.push_back(rid);
                    void'(rq.pop_front());
                    if (rq.size() == 0) r_busy = 0;
                end
            end
            exp_bv = b_pend && cyc >= b_start;
            chk("bvalid", 32'(bvalid), 32'(exp_bv));
            if (bvalid && exp_bv) begin
                chk("bid", 32'(bid), 32'(w_id_m));
                chk("bresp", 32'(bresp), w_err_m ? 32'd2 : 32'd0);
                if (bready) begin
                    last_bresp = bresp;
                    b_pend = 0;
                    w_busy = 0;
                end
            end
            if (wvalid && wready && w_busy && wq.size() > 0) begin
                idx = wq.pop_front();
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) begin
                        mm[idx][8*b +: 8] = wdata[8*b +: 8];
                        mk[idx][b] = 1'b1;
                    end
                end
                is_last = (wq.size() == 0);
                if (wlast != is_last) w_err_m = 1;
                if (is_last) begin
                    b_pend = 1;
                    b_start = cyc + 1;
                end
            end
            if (arvalid && arready && !r_busy) begin
                for (int i = 0; i <= int'(arlen); i++)
                    rq.push_back((beat_addr(araddr, 32'(arlen),
                                  32'(arburst), i) / 4) % 1024);
                r_busy = 1;
                r_start = cyc + 1 + LAT;
                r_id_m = arid;
                ar_cyc = cyc;
                first_wait = 1;
            end
            if (awvalid && awready && !w_busy) begin
                for (int i = 0; i <= int'(awlen); i++)
                    wq.push_back((beat_addr(awaddr, 32'(awlen),
                                  32'(awburst), i) / 4) % 1024);
                w_busy = 1;
                w_start = cyc + 1;
                w_id_m = awid;
                w_err_m = 0;
            end
        end
    end

    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic ar_send(input logic [31:0] a, input logic [3:0] len,
                           input logic [1:0] bt, input logic [3:0] id);
        bit hs = 0;
        araddr = a; arlen = len; arburst = bt; arid = id; arvalid = 1'b1;
        for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        if (!hs) timeout("ar");
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] len,
                           input logic [1:0] bt, input logic [3:0] id);
        got_d.delete();
        got_l.delete();
        got_id.delete();
        ar_send(a, len, bt, id);
        for (int n = 0; n < 400 && got_d.size() < int'(len) + 1; n++) begin
            rready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        rready = 1'b0;
        if (got_d.size() < int'(len) + 1) timeout("r");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] len,
                            input logic [1:0] bt, input logic [3:0] id,
                            input int early);
        bit hs = 0;
        awaddr = a; awlen = len; awburst = bt; awid = id; awvalid = 1'b1;
        for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk);
            hs = awready;
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        if (!hs) begin
            timeout("aw");
            return;
        end
        for (int i = 0; i <= int'(len); i++) begin
            hs = 0;
            wdata = wd[i];
            wstrb = ws[i];
            wlast = (early >= 0) ? (i == early) : (i == int'(len));
            for (int n = 0; n < 100 && !hs; n++) begin
                wvalid = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                hs = wvalid && wready;
                @(posedge clk);
                #1;
            end
            if (!hs) begin
                timeout("w");
                break;
            end
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        hs = 0;
        for (int n = 0; n < 100 && !hs; n++) begin
            bready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            hs = bvalid && bready;
            @(posedge clk);
            #1;
        end
        bready = 1'b0;
        if (!hs) timeout("b");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  len;
        logic [1:0]  bt;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(32'h40, 4'd0, 2'b01, 4'd3, -1);
        chk("single_bresp", 32'(last_bresp), 32'd0);
        do_read(32'h40, 4'd0, 2'b01, 4'd5);
        chk("single_data", got_d[0], 32'hDEADBEEF);
        chk("single_last", 32'(got_l[0]), 32'd1);
        chk("single_rid", 32'(got_id[0]), 32'd5);
        chk("latency", 32'(first_rv_cyc - ar_cyc), 32'd4);

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i + 1);
            ws[i] = 4'hF;
        end
        do_write(32'h100, 4'd3, 2'b01, 4'd1, -1);
        do_read(32'h100, 4'd3, 2'b01, 4'd2);
        for (int i = 0; i < 4; i++) begin
            chk("incr_data", got_d[i], 32'(i + 1));
            chk("incr_last", 32'(got_l[i]), 32'(i == 3));
        end

        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        do_write(32'h100, 4'd3, 2'b01, 4'd1, -1);
        do_read(32'h108, 4'd3, 2'b10, 4'd7);
        chk("wrap_b0", got_d[0], 32'hC);
        chk("wrap_b1", got_d[1], 32'hD);
        chk("wrap_b2", got_d[2], 32'hA);
        chk("wrap_b3", got_d[3], 32'hB);

        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(32'h200, 4'd0, 2'b01, 4'd2, -1);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(32'h200, 4'd0, 2'b01, 4'd2, -1);
        do_read(32'h200, 4'd0, 2'b00, 4'd2);
        chk("strobe_data", got_d[0], 32'h11BB33DD);

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'h5000 + 32'(i);
            ws[i] = 4'hF;
        end
        do_write(32'h300, 4'd3, 2'b01, 4'd6, 1);
        chk("early_wlast_bresp", 32'(last_bresp), 32'd2);
        do_read(32'h300, 4'd3, 2'b01, 4'd6);
        chk("early_wlast_data", got_d[3], 32'h5003);

        ar_send(32'h100, 4'd7, 2'b01, 4'd9);
        rready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_arready", 32'(arready), 32'd1);
        chk("post_reset_rvalid", 32'(rvalid), 32'd0);
        @(posedge clk);
        #1;
        do_read(32'h40, 4'd0, 2'b01, 4'd1);
        chk("retained_40", got_d[0], 32'hDEADBEEF);
        do_read(32'h100, 4'd0, 2'b01, 4'd1);
        chk("retained_100", got_d[0], 32'hA);

        for (int t = 0; t < 30; t++) begin
            a = 32'h400 + 32'(4 * $urandom_range(0, 700));
            len = 4'($urandom_range(0, 15));
            bt = 2'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'($urandom_range(0, 15));
            end
            do_write(a, len, bt, 4'($urandom_range(0, 15)), -1);
            if ($urandom_range(0, 1) == 1)
                len = 4'($urandom_range(0, 15));
            do_read(a, len, bt, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
